// File: rtl/object_scanner.sv
// Object table scanner: holds object property words and walks them in index order,
// issuing each non-empty slot to the downstream converter with stall support.
module object_scanner #(
    parameter int unsigned NUM_OBJECTS = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_OBJECTS),
    localparam int unsigned WORD_W     = 115,
    localparam int unsigned CNT_W      = IDX_W + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              wr_en_in,
    input  logic [IDX_W-1:0]  wr_addr_in,
    input  logic [WORD_W-1:0] wr_data_in,
    input  logic              downstream_busy_in,
    output logic [WORD_W-1:0] obj_props_out,
    output logic [1:0]        obj_type_out,
    output logic [IDX_W-1:0]  obj_index_out,
    output logic              obj_valid_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [CNT_W-1:0]  obj_count_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  addr_q;
    logic [WORD_W-1:0] props_q;
    logic [WORD_W-1:0] table_q [NUM_OBJECTS];

    logic              addr_last_c;
    logic              slot_empty_c;
    logic [IDX_W-1:0]  addr_d;

    assign addr_last_c  = (addr_q == IDX_W'(NUM_OBJECTS - 1));
    assign slot_empty_c = (props_q[113:112] == 2'b00);
    assign addr_d       = addr_q + IDX_W'(1);

    // Object table; reset clears every slot to the empty type.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(NUM_OBJECTS); i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en_in) begin
            table_q[wr_addr_in] <= wr_data_in;
        end
    end

    // Scan FSM with registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            props_q       <= '0;
            obj_props_out <= '0;
            obj_type_out  <= '0;
            obj_index_out <= '0;
            obj_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            obj_count_out <= '0;
        end else begin
            obj_valid_out <= 1'b0;
            done_out      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A start coinciding with the done pulse belongs to the finished scan.
                    if (start_in && !done_out) begin
                        addr_q        <= '0;
                        busy_out      <= 1'b1;
                        obj_count_out <= '0;
                        state_q       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    props_q <= table_q[addr_q];
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (slot_empty_c) begin
                        if (addr_last_c) begin
                            state_q <= S_FINISH;
                        end else begin
                            addr_q  <= addr_d;
                            state_q <= S_FETCH;
                        end
                    end else if (!downstream_busy_in) begin
                        obj_valid_out <= 1'b1;
                        obj_props_out <= props_q;
                        obj_type_out  <= props_q[113:112];
                        obj_index_out <= addr_q;
                        obj_count_out <= obj_count_out + CNT_W'(1);
                        state_q       <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (addr_last_c) begin
                        state_q <= S_FINISH;
                    end else begin
                        addr_q  <= addr_d;
                        state_q <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_object_scanner.sv
// Bench for object_scanner: slot-walk reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_object_scanner;

    localparam int N     = 8;
    localparam int IDX_W = 3;
    localparam int W     = 115;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             start_in;
    logic             wr_en_in;
    logic [IDX_W-1:0] wr_addr_in;
    logic [W-1:0]     wr_data_in;
    logic             downstream_busy_in;
    logic [W-1:0]     obj_props_out;
    logic [1:0]       obj_type_out;
    logic [IDX_W-1:0] obj_index_out;
    logic             obj_valid_out;
    logic             busy_out;
    logic             done_out;
    logic [IDX_W:0]   obj_count_out;

    object_scanner #(.NUM_OBJECTS(N)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .start_in           (start_in),
        .wr_en_in           (wr_en_in),
        .wr_addr_in         (wr_addr_in),
        .wr_data_in         (wr_data_in),
        .downstream_busy_in (downstream_busy_in),
        .obj_props_out      (obj_props_out),
        .obj_type_out       (obj_type_out),
        .obj_index_out      (obj_index_out),
        .obj_valid_out      (obj_valid_out),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .obj_count_out      (obj_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Reference model: the scan as a walk over slots, each slot read then decided upon.
    logic [W-1:0]     m_table [N];
    logic [W-1:0]     m_cap;
    bit               m_scan, m_cap_ok, m_after, m_finish;
    int               m_slot;
    logic             e_valid, e_busy, e_done;
    logic [W-1:0]     e_props;
    logic [1:0]       e_type;
    logic [IDX_W-1:0] e_idx;
    logic [IDX_W:0]   e_count;

    task automatic move_on();
        if (m_slot == N - 1) m_finish = 1'b1;
        else m_slot++;
    endtask

    always @(posedge clk_in) begin
        logic done_prev;
        done_prev = e_done;
        if (rst_in) begin
            for (int i = 0; i < N; i++) m_table[i] = '0;
            m_scan = 0; m_cap_ok = 0; m_after = 0; m_finish = 0; m_slot = 0; m_cap = '0;
            e_valid = 0; e_busy = 0; e_done = 0; e_props = '0; e_type = '0; e_idx = '0; e_count = '0;
        end else begin
            e_valid = 1'b0;
            e_done  = 1'b0;
            if (m_finish) begin
                m_finish = 0; m_scan = 0; e_busy = 0; e_done = 1'b1;
            end else if (m_scan) begin
                if (m_after) begin
                    m_after = 0;
                    move_on();
                end else if (!m_cap_ok) begin
                    m_cap    = m_table[m_slot];
                    m_cap_ok = 1;
                end else if (m_cap[113:112] == 2'b00) begin
                    m_cap_ok = 0;
                    move_on();
                end else if (!downstream_busy_in) begin
                    e_valid  = 1'b1;
                    e_props  = m_cap;
                    e_type   = m_cap[113:112];
                    e_idx    = IDX_W'(m_slot);
                    e_count  = e_count + 1'b1;
                    m_cap_ok = 0;
                    m_after  = 1;
                end
            end else if (start_in && !done_prev) begin
                m_scan = 1; m_slot = 0; m_cap_ok = 0; m_after = 0;
                e_busy = 1'b1; e_count = '0;
            end
            if (wr_en_in) m_table[wr_addr_in] = wr_data_in;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("valid", W'(obj_valid_out), W'(e_valid));
            chk("busy",  W'(busy_out),      W'(e_busy));
            chk("done",  W'(done_out),      W'(e_done));
            chk("count", W'(obj_count_out), W'(e_count));
            chk("props", obj_props_out,     e_props);
            chk("type",  W'(obj_type_out),  W'(e_type));
            chk("index", W'(obj_index_out), W'(e_idx));
        end
    end

    // Issue/done recorder for the directed literal checks.
    int           q_idx [$];
    int           q_type[$];
    logic [W-1:0] q_props[$];
    int           q_cyc [$];
    int           done_cnt = 0;

    always @(negedge clk_in) begin
        if (obj_valid_out) begin
            q_idx.push_back(int'(obj_index_out));
            q_type.push_back(int'(obj_type_out));
            q_props.push_back(obj_props_out);
            q_cyc.push_back(cyc);
        end
        if (done_out) done_cnt++;
    end

    int start_cyc;
    int done_at;

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        wr_en_in = 1'b1; wr_addr_in = IDX_W'(a); wr_data_in = d;
        tick();
        wr_en_in = 1'b0;
    endtask

    task automatic start_scan();
        q_idx.delete(); q_type.delete(); q_props.delete(); q_cyc.delete();
        start_in = 1'b1;
        tick();
        start_in  = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (done_out) begin
                seen    = 1;
                done_at = cyc;
            end
        end
        chk("done_seen", W'(seen), W'(1));
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return W'(r);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] w0, w3, w7, wa, wb, wc;
        int d0;

        rst_in = 1'b1; start_in = 1'b0; wr_en_in = 1'b0; wr_addr_in = '0;
        wr_data_in = '0; downstream_busy_in = 1'b0;
        @(negedge clk_in);
        tick();
        rst_in = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", W'(obj_valid_out), W'(0));
        chk("rst_busy",  W'(busy_out),      W'(0));
        chk("rst_count", W'(obj_count_out), W'(0));

        // Empty table: done after start edge + 2*N + 1.
        start_scan();
        wait_done(60);
        chk("empty_done_lat", W'(done_at - start_cyc), W'(2 * N + 1));
        chk("empty_no_valid", W'(q_idx.size()), W'(0));
        chk("empty_count", W'(obj_count_out), W'(0));

        // Three objects at slots 0, 3, 7.
        w0 = '0; w0[113:112] = 2'b01; w0[111:96] = 16'd100; w0[95:80] = 16'd200; w0[79:64] = 16'd10;
        w3 = rand_word(); w3[113:112] = 2'b11;
        w7 = rand_word(); w7[113:112] = 2'b10;
        wr(0, w0); wr(3, w3); wr(7, w7);
        start_scan();
        wait_done(60);
        chk("three_n", W'(q_idx.size()), W'(3));
        if (q_idx.size() == 3) begin
            chk("three_idx0", W'(q_idx[0]), W'(0));
            chk("three_idx1", W'(q_idx[1]), W'(3));
            chk("three_idx2", W'(q_idx[2]), W'(7));
            chk("three_type0", W'(q_type[0]), W'(1));
            chk("three_type1", W'(q_type[1]), W'(3));
            chk("three_type2", W'(q_type[2]), W'(2));
            chk("three_lat0", W'(q_cyc[0] - start_cyc), W'(2));
            chk("three_props0", q_props[0], w0);
            chk("three_props2", q_props[2], w7);
        end
        chk("three_count", W'(obj_count_out), W'(3));

        // Stall at slot 2 for five CHECK edges.
        wr(0, '0); wr(3, '0); wr(7, '0);
        wa = rand_word(); wa[113:112] = 2'b10;
        wr(2, wa);
        downstream_busy_in = 1'b1;
        start_scan();
        for (int k = 0; k < 40 && (cyc - start_cyc) < 10; k++) tick();
        chk("stall_no_valid", W'(q_idx.size()), W'(0));
        downstream_busy_in = 1'b0;
        wait_done(60);
        chk("stall_n", W'(q_idx.size()), W'(1));
        if (q_idx.size() == 1) begin
            chk("stall_lat", W'(q_cyc[0] - start_cyc), W'(11));
            chk("stall_idx", W'(q_idx[0]), W'(2));
        end

        // Rewrite the latched slot and a not-yet-fetched slot mid-scan.
        wb = rand_word(); wb[113:112] = 2'b01;
        wc = rand_word(); wc[113:112] = 2'b01;
        wr(1, wb);
        downstream_busy_in = 1'b1;
        start_scan();
        for (int k = 0; k < 40 && (cyc - start_cyc) < 4; k++) tick();
        wr(1, rand_word());
        wr_en_in = 1'b1; wr_addr_in = 3'd5; wr_data_in = wc; downstream_busy_in = 1'b0;
        tick();
        wr_en_in = 1'b0;
        wait_done(60);
        chk("rw_n", W'(q_idx.size()), W'(3));
        if (q_idx.size() == 3) begin
            chk("rw_idx0", W'(q_idx[0]), W'(1));
            chk("rw_latched_props", q_props[0], wb);
            chk("rw_idx2", W'(q_idx[2]), W'(5));
            chk("rw_new_props", q_props[2], wc);
        end

        // Starts mid-scan and in the done cycle are ignored.
        wr(1, wb);
        d0 = done_cnt;
        start_scan();
        tick(); tick();
        start_in = 1'b1; tick(); start_in = 1'b0;
        wait_done(80);
        start_in = 1'b1; tick(); start_in = 1'b0;
        chk("ign_busy", W'(busy_out), W'(0));
        tick(); tick();
        chk("ign_busy2", W'(busy_out), W'(0));
        chk("ign_one_done", W'(done_cnt - d0), W'(1));
        chk("ign_n", W'(q_idx.size()), W'(3));

        // Reset mid-scan after the first issue.
        start_scan();
        for (int k = 0; k < 40 && q_idx.size() == 0; k++) tick();
        chk("rstm_issued", W'(q_idx.size()), W'(1));
        d0 = done_cnt;
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        chk("rstm_valid", W'(obj_valid_out), W'(0));
        chk("rstm_busy",  W'(busy_out),      W'(0));
        chk("rstm_count", W'(obj_count_out), W'(0));
        chk("rstm_props", obj_props_out,     W'(0));
        chk("rstm_index", W'(obj_index_out), W'(0));
        for (int k = 0; k < 20; k++) tick();
        chk("rstm_no_done", W'(done_cnt - d0), W'(0));
        start_scan();
        wait_done(60);
        chk("rstm_empty_n", W'(q_idx.size()), W'(0));
        chk("rstm_empty_count", W'(obj_count_out), W'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] d;
            d = rand_word();
            d[113:112] = ($urandom_range(0, 9) < 4) ? 2'b00 : 2'($urandom_range(1, 3));
            rst_in             = ($urandom_range(0, 399) == 0);
            start_in           = ($urandom_range(0, 14) == 0);
            wr_en_in           = ($urandom_range(0, 3) == 0);
            wr_addr_in         = IDX_W'($urandom_range(0, N - 1));
            wr_data_in         = d;
            downstream_busy_in = ($urandom_range(0, 1) == 1);
            tick();
        end
        rst_in = 1'b0; start_in = 1'b0; wr_en_in = 1'b0; downstream_busy_in = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
